// File: rtl/mempool_l2_banked_mem_pkg.sv
// Shared constants and helpers for the banked L2 memory.
// Holds the default L2 geometry and the L2 base/end address derivation.
package mempool_l2_banked_mem_pkg;

  localparam int unsigned L2NumBanks    = 4;
  localparam int unsigned L2BankWords   = 1024;
  localparam int unsigned L2SramLatency = 1;
  localparam int unsigned L2DataWidth   = 512;

  // L2 window in the global address map; the size follows from the bank geometry.
  localparam logic [31:0] L2BaseAddr  = 32'h8000_0000;
  localparam logic [31:0] L2SizeBytes = L2NumBanks * L2BankWords * (L2DataWidth / 8);
  localparam logic [31:0] L2EndAddr   = L2BaseAddr + L2SizeBytes;

  // Index width that never collapses to zero bits for a single-entry selector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mempool_l2_banked_mem_bank.sv
// One L2 bank: round-robin arbiter over all ports, byte-enable SRAM,
// SramLatency-deep read data pipeline and a matching {valid, port} metadata
// shift register. The tail of both pipelines forms the bank response.
module mempool_l2_banked_mem_bank
  import mempool_l2_banked_mem_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned DataWidth   = 512,
  parameter int unsigned BankWords   = 1024,
  parameter int unsigned SramLatency = 1,
  localparam int unsigned StrbWidth  = DataWidth / 8,
  localparam int unsigned RowW       = idx_width(BankWords),
  localparam int unsigned PortW      = idx_width(NumPorts)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][RowW-1:0]       row_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][StrbWidth-1:0]  strb_i,
  output logic                                tail_valid_o,
  output logic [PortW-1:0]                    tail_port_o,
  output logic [DataWidth-1:0]                tail_data_o,
  output logic                                busy_o
);

  logic [NumPorts-1:0]                   w_req;
  logic                                  w_win_valid;
  logic [PortW-1:0]                      w_win_idx;
  logic [PortW-1:0]                      r_rr_ptr;
  logic                                  w_sel_we;
  logic [RowW-1:0]                       w_sel_row;
  logic [DataWidth-1:0]                  w_sel_wdata;
  logic [StrbWidth-1:0]                  w_sel_strb;
  logic [DataWidth-1:0]                  r_mem [BankWords];
  logic [SramLatency-1:0][DataWidth-1:0] r_data;
  logic [SramLatency-1:0]                r_meta_v;
  logic [SramLatency-1:0][PortW-1:0]     r_meta_p;

  // Requests are masked during reset so no grant can leak out.
  assign w_req = req_i & {NumPorts{rst_ni}};

  // Round-robin pick: first requester at or after the pointer, wrapping once.
  always_comb begin
    int unsigned w_cand;
    w_cand      = 0;
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      w_cand = int'(r_rr_ptr) + i;
      if (w_cand >= NumPorts) w_cand = w_cand - NumPorts;
      if (!w_win_valid && w_req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = PortW'(w_cand);
      end
    end
  end

  // One-hot grant back to the winning port.
  always_comb begin
    gnt_o = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      gnt_o[p] = w_win_valid && (w_win_idx == PortW'(p));
    end
  end

  assign w_sel_we    = we_i[w_win_idx];
  assign w_sel_row   = row_i[w_win_idx];
  assign w_sel_wdata = wdata_i[w_win_idx];
  assign w_sel_strb  = strb_i[w_win_idx];

  // Pointer moves past the winner; it holds while the bank is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_win_valid) begin
      r_rr_ptr <= (w_win_idx == PortW'(NumPorts - 1)) ? '0 : w_win_idx + PortW'(1);
    end
  end

  // SRAM array write with byte enables; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_win_valid && w_sel_we) begin
      for (int b = 0; b < int'(StrbWidth); b++) begin
        if (w_sel_strb[b]) r_mem[w_sel_row][b*8 +: 8] <= w_sel_wdata[b*8 +: 8];
      end
    end
  end

  // SRAM read register followed by SramLatency-1 output stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data <= '0;
    end else begin
      if (w_win_valid && !w_sel_we) r_data[0] <= r_mem[w_sel_row];
      for (int s = 1; s < int'(SramLatency); s++) begin
        r_data[s] <= r_data[s-1];
      end
    end
  end

  // Metadata travels alongside the data so the tail names the owning port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta_v <= '0;
      r_meta_p <= '0;
    end else begin
      r_meta_v[0] <= w_win_valid;
      r_meta_p[0] <= w_win_idx;
      for (int s = 1; s < int'(SramLatency); s++) begin
        r_meta_v[s] <= r_meta_v[s-1];
        r_meta_p[s] <= r_meta_p[s-1];
      end
    end
  end

  assign tail_valid_o = r_meta_v[SramLatency-1];
  assign tail_port_o  = r_meta_p[SramLatency-1];
  assign tail_data_o  = r_data[SramLatency-1];
  assign busy_o       = |r_meta_v;

endmodule

// File: rtl/mempool_l2_banked_mem.sv
// Banked L2 memory: decodes each port's byte address into bank and row,
// fans requests out to word-interleaved banks, merges grants and routes
// each bank's tail response back to the port recorded in its metadata.
module mempool_l2_banked_mem
  import mempool_l2_banked_mem_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned NumBanks    = L2NumBanks,
  parameter int unsigned DataWidth   = L2DataWidth,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned BankWords   = L2BankWords,
  parameter int unsigned SramLatency = L2SramLatency,
  localparam int unsigned StrbWidth  = DataWidth / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  output logic [NumPorts-1:0]                 gnt_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][StrbWidth-1:0]  strb_i,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic                                busy_o
);

  localparam int unsigned ByteOff = $clog2(StrbWidth);
  localparam int unsigned BankSel = $clog2(NumBanks);
  localparam int unsigned BankW   = idx_width(NumBanks);
  localparam int unsigned RowW    = idx_width(BankWords);
  localparam int unsigned PortW   = idx_width(NumPorts);

  logic [NumPorts-1:0][BankW-1:0]          w_bank;
  logic [NumPorts-1:0][RowW-1:0]           w_row;
  logic [NumBanks-1:0][NumPorts-1:0]       w_bank_req;
  logic [NumBanks-1:0][NumPorts-1:0]       w_bank_gnt;
  logic [NumBanks-1:0]                     w_tail_valid;
  logic [NumBanks-1:0][PortW-1:0]          w_tail_port;
  logic [NumBanks-1:0][DataWidth-1:0]      w_tail_data;
  logic [NumBanks-1:0]                     w_busy;
  logic                                    w_unused_addr;

  // Byte offset and bits above the bank array are intentionally dropped (wrap).
  assign w_unused_addr = ^addr_i;

  for (genvar p = 0; p < NumPorts; p++) begin : g_dec
    assign w_row[p] = addr_i[p][ByteOff+BankSel +: RowW];
    if (NumBanks > 1) begin : g_multi
      assign w_bank[p] = addr_i[p][ByteOff +: BankSel];
    end else begin : g_single
      assign w_bank[p] = '0;
    end
  end

  // Route each port's request to the bank its address selects.
  always_comb begin
    w_bank_req = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        w_bank_req[b][p] = req_i[p] && (w_bank[p] == BankW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    mempool_l2_banked_mem_bank #(
      .NumPorts    (NumPorts),
      .DataWidth   (DataWidth),
      .BankWords   (BankWords),
      .SramLatency (SramLatency)
    ) u_bank (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (w_bank_req[b]),
      .gnt_o        (w_bank_gnt[b]),
      .we_i         (we_i),
      .row_i        (w_row),
      .wdata_i      (wdata_i),
      .strb_i       (strb_i),
      .tail_valid_o (w_tail_valid[b]),
      .tail_port_o  (w_tail_port[b]),
      .tail_data_o  (w_tail_data[b]),
      .busy_o       (w_busy[b])
    );
  end

  // A port targets one bank per cycle, so OR-merging bank grants is exact.
  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < int'(NumBanks); b++) begin
      gnt_o = gnt_o | w_bank_gnt[b];
    end
  end

  // Fixed latency means at most one bank tail can name a given port.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (w_tail_valid[b] && (w_tail_port[b] == PortW'(p))) begin
          rvalid_o[p] = 1'b1;
          rdata_o[p]  = w_tail_data[b];
        end
      end
    end
  end

  assign busy_o = |w_busy;

endmodule

// File: tb/tb_mempool_l2_banked_mem.sv
// Directed bench for the banked L2 memory. Two instances share the stimulus:
// one with SramLatency=1 and one with SramLatency=3, so every grant is seen
// one cycle later on the first and three cycles later on the second.
module tb_mempool_l2_banked_mem;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int BW = 1024;
  localparam int SW = DW / 8;

  localparam logic [DW-1:0] D11    = {64{8'h11}};
  localparam logic [DW-1:0] D22    = {64{8'h22}};
  localparam logic [DW-1:0] D33    = {64{8'h33}};
  localparam logic [DW-1:0] D44    = {64{8'h44}};
  localparam logic [DW-1:0] DA5    = {64{8'hA5}};
  localparam logic [DW-1:0] D5A    = {64{8'h5A}};
  localparam logic [DW-1:0] DC3    = {64{8'hC3}};
  localparam logic [DW-1:0] D3C    = {64{8'h3C}};
  localparam logic [DW-1:0] DEE    = {64{8'hEE}};
  localparam logic [DW-1:0] MERGED = {{56{8'hA5}}, {8{8'hEE}}};
  localparam logic [SW-1:0] ALL    = {SW{1'b1}};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni;

  logic [NP-1:0]         req;
  logic [NP-1:0]         we;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][DW-1:0] wdata;
  logic [NP-1:0][SW-1:0] strb;

  logic [NP-1:0]         gnt1, gnt3, rv1, rv3;
  logic [NP-1:0][DW-1:0] rd1, rd3;
  logic                  busy1, busy3;

  int checks = 0;
  int errors = 0;

  mempool_l2_banked_mem #(
    .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
    .BankWords(BW), .SramLatency(1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rv1), .rdata_o(rd1),
    .busy_o(busy1)
  );

  mempool_l2_banked_mem #(
    .NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
    .BankWords(BW), .SramLatency(3)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt3), .addr_i(addr),
    .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rv3), .rdata_o(rd3),
    .busy_o(busy3)
  );

  // checker
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drv(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [SW-1:0] s);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    strb[p]  = s;
  endtask

  task automatic drop(input int p);
    req[p] = 1'b0;
    we[p]  = 1'b0;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] t3_data [4];
  logic [AW-1:0] t3_addr [4];

  initial begin
    t3_data = '{DA5, D5A, DC3, D3C};
    t3_addr = '{32'h0000_0000, 32'h0000_0040, 32'h0000_0080, 32'h0000_00C0};

    // reset: requests present but masked
    rst_ni = 1'b0;
    req = 2'b11; we = '0; addr = '0; wdata = '0; strb = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt1", gnt1, 0);
    chk("rst_gnt3", gnt3, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_rv3", rv3, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_rd1", rd1[0], 0);
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // bank 0 contention: P0,P1,P0,P1 with losers holding
    drv(0, 1'b1, 32'h000, D11, ALL);
    drv(1, 1'b1, 32'h100, D22, ALL);
    #1; chk("rr_g0_1", gnt1, 2'b01); chk("rr_g0_3", gnt3, 2'b01);
    tick();
    chk("rr_rv0", rv1, 2'b01); chk("rr_busy1", busy1, 1);
    drv(0, 1'b1, 32'h200, D33, ALL);
    #1; chk("rr_g1", gnt1, 2'b10);
    tick();
    chk("rr_rv1", rv1, 2'b10);
    drv(1, 1'b1, 32'h300, D44, ALL);
    #1; chk("rr_g2", gnt1, 2'b01);
    tick();
    chk("rr_rv2", rv1, 2'b01); chk("rr_rv3_0", rv3, 2'b01);
    drop(0);
    #1; chk("rr_g3_1", gnt1, 2'b10); chk("rr_g3_3", gnt3, 2'b10);
    tick();
    chk("rr_rv3", rv1, 2'b10); chk("rr_rv3_1", rv3, 2'b10);
    idle();
    tick();
    chk("rr_rv3_2", rv3, 2'b01);
    tick();
    chk("rr_rv3_3", rv3, 2'b10);
    tick();
    chk("rr_rv3_idle", rv3, 0); chk("idle_busy1", busy1, 0); chk("idle_busy3", busy3, 0);

    // parallel writes to distinct banks, then readback
    drv(0, 1'b1, 32'h000, DA5, ALL);
    drv(1, 1'b1, 32'h040, D5A, ALL);
    #1; chk("par_gw0", gnt1, 2'b11);
    tick();
    chk("par_rvw0", rv1, 2'b11);
    drv(0, 1'b1, 32'h080, DC3, ALL);
    drv(1, 1'b1, 32'h0C0, D3C, ALL);
    #1; chk("par_gw1", gnt1, 2'b11);
    tick();
    chk("par_rvw1", rv1, 2'b11);
    drv(0, 1'b0, 32'h000, '0, ALL);
    drv(1, 1'b0, 32'h040, '0, ALL);
    #1; chk("par_gr1", gnt1, 2'b11); chk("par_gr3", gnt3, 2'b11);
    tick();
    chk("par_rvr", rv1, 2'b11);
    chk("par_rd1_p0", rd1[0], DA5);
    chk("par_rd1_p1", rd1[1], D5A);
    chk("par_rv3w0", rv3, 2'b11);
    idle();
    tick();
    chk("par_rv3w1", rv3, 2'b11);
    tick();
    chk("par_rv3r", rv3, 2'b11);
    chk("par_rd3_p0", rd3[0], DA5);
    chk("par_rd3_p1", rd3[1], D5A);
    tick();

    // back-to-back reads over banks 0..3 from port 0
    for (int k = 0; k < 7; k++) begin
      chk("b2b_rv1", rv1[0], (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk("b2b_rd1", rd1[0], t3_data[k-1]);
      chk("b2b_rv3", rv3[0], (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("b2b_rd3", rd3[0], t3_data[k-3]);
      if (k < 4) begin
        drv(0, 1'b0, t3_addr[k], '0, ALL);
        #1; chk("b2b_gnt", gnt1, 2'b01);
      end else begin
        idle();
      end
      tick();
    end

    // partial write then immediate read of the same word
    drv(0, 1'b1, 32'h000, DEE, 64'h0000_0000_0000_00FF);
    #1; chk("strb_gw", gnt1, 2'b01);
    tick();
    drv(0, 1'b0, 32'h000, '0, ALL);
    #1; chk("strb_gr", gnt1, 2'b01);
    tick();
    chk("strb_rv1", rv1, 2'b01);
    chk("strb_rd1", rd1[0], MERGED);
    idle();
    tick();
    tick();
    chk("strb_rv3", rv3, 2'b01);
    chk("strb_rd3", rd3[0], MERGED);

    // high address bits alias back to word 0
    drv(1, 1'b0, 32'h0010_0000, '0, ALL);
    #1; chk("wrap_g", gnt1, 2'b10);
    tick();
    chk("wrap_rv1", rv1, 2'b10);
    chk("wrap_rd1", rd1[1], MERGED);
    idle();
    tick();
    tick();
    chk("wrap_rv3", rv3, 2'b10);
    chk("wrap_rd3", rd3[1], MERGED);

    // reset with reads in flight; bank 0 pointer was left at port 1
    drv(0, 1'b0, 32'h000, '0, ALL);
    drv(1, 1'b0, 32'h040, '0, ALL);
    #1; chk("fl_g", gnt1, 2'b11);
    tick();
    chk("fl_rv1", rv1, 2'b11);
    chk("fl_busy3", busy3, 1);
    drv(0, 1'b0, 32'h000, '0, ALL);
    drv(1, 1'b0, 32'h100, '0, ALL);
    rst_ni = 1'b0;
    #1;
    chk("rst2_rv1", rv1, 0);
    chk("rst2_rv3", rv3, 0);
    chk("rst2_busy1", busy1, 0);
    chk("rst2_busy3", busy3, 0);
    chk("rst2_gnt1", gnt1, 0);
    idle();
    tick();
    tick();
    chk("rst2_rv3_hold", rv3, 0);
    chk("rst2_busy3_hold", busy3, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    chk("post_rv1", rv1, 0);
    chk("post_rv3", rv3, 0);
    chk("post_rd3", rd3[0], 0);
    drv(0, 1'b0, 32'h000, '0, ALL);
    drv(1, 1'b0, 32'h100, '0, ALL);
    #1; chk("post_ptr1", gnt1, 2'b01); chk("post_ptr3", gnt3, 2'b01);
    tick();
    chk("post_rv1_p0", rv1, 2'b01);
    chk("post_rd1_p0", rd1[0], MERGED);
    idle();
    tick();
    tick();
    chk("post_rv3_p0", rv3, 2'b01);
    chk("post_rd3_p0", rd3[0], MERGED);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
